// File: rtl/sar_seq_ctrl_if.sv
// Handshake and converter bus for the SAR sequencer: control requests in,
// sample/DAC drive and result status out.
interface sar_seq_ctrl_if #(
  parameter int unsigned NBITS = 8
);
  logic             ena;
  logic             start;
  logic             cmp;
  logic             ack;
  logic             sample;
  logic [NBITS-1:0] dac;
  logic [NBITS-1:0] result;
  logic             valid;
  logic             busy;
  logic             ovr;

  modport master (
    output ena, start, cmp, ack,
    input  sample, dac, result, valid, busy, ovr
  );

  modport slave (
    input  ena, start, cmp, ack,
    output sample, dac, result, valid, busy, ovr
  );
endinterface

// File: rtl/sar_seq_ctrl.sv
// Successive-approximation ADC sequencer: sample phase, MSB-first binary
// search driven by the comparator, then result hand-off with overrun tracking.
module sar_seq_ctrl #(
  parameter int unsigned NBITS         = 8,
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  sar_seq_ctrl_if.slave bus
);

  localparam int unsigned     IW        = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [3:0]      CNT_LOAD  = 4'(SAMPLE_CYCLES - 1);
  localparam logic [IW-1:0]   IDX_TOP   = IW'(NBITS - 1);
  localparam logic [IW-1:0]   IDX_ONE   = IW'(1);
  localparam logic [NBITS-1:0] TRIAL_MSB = NBITS'(1) << (NBITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sample;
  logic             w_sample_nxt;
  logic [NBITS-1:0] r_dac;
  logic [NBITS-1:0] w_dac_nxt;
  logic [NBITS-1:0] r_result;
  logic [NBITS-1:0] w_result_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_ovr;
  logic             w_ovr_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;

  logic [NBITS-1:0] w_code;
  logic [NBITS-1:0] w_trial;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a low enable overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.ena) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    if (bus.start) w_state_nxt = ST_SAMPLE;
        ST_SAMPLE:  if (r_cnt == '0) w_state_nxt = ST_CONVERT;
        ST_CONVERT: if (r_idx == '0) w_state_nxt = ST_DONE;
        ST_DONE:    w_state_nxt = bus.start ? ST_SAMPLE : ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Bit decision for the current trial, and the next trial with the
  // following lower bit raised.
  always_comb begin
    w_code = r_dac;
    if (!bus.cmp) begin
      w_code[r_idx] = 1'b0;
    end
    w_trial = w_code;
    if (r_idx != '0) begin
      w_trial[r_idx - IDX_ONE] = 1'b1;
    end
  end

  // Output logic: registered outputs are decided by the state being entered,
  // so sample/dac line up with the state they belong to.
  always_comb begin
    w_sample_nxt = (w_state_nxt == ST_SAMPLE);
    w_dac_nxt    = '0;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_result_nxt = r_result;
    w_valid_nxt  = r_valid;
    w_ovr_nxt    = r_ovr;

    if (bus.ack) begin
      w_valid_nxt = 1'b0;
    end

    unique case (w_state_nxt)
      ST_SAMPLE: begin
        w_cnt_nxt = (r_state == ST_SAMPLE) ? (r_cnt - 4'd1) : CNT_LOAD;
      end
      ST_CONVERT: begin
        if (r_state == ST_SAMPLE) begin
          w_dac_nxt = TRIAL_MSB;
          w_idx_nxt = IDX_TOP;
        end else begin
          w_dac_nxt = w_trial;
          w_idx_nxt = r_idx - IDX_ONE;
        end
      end
      ST_DONE: begin
        // Completion wins over a coincident ack; overrun only if unread data is lost
        w_result_nxt = w_code;
        w_valid_nxt  = 1'b1;
        if (r_valid && !bus.ack) begin
          w_ovr_nxt = 1'b1;
        end
      end
      default: begin
        w_dac_nxt = '0;
      end
    endcase

    if (!bus.ena) begin
      w_ovr_nxt = 1'b0;
      w_cnt_nxt = '0;
      w_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= 1'b0;
      r_dac    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
    end else begin
      r_sample <= w_sample_nxt;
      r_dac    <= w_dac_nxt;
      r_result <= w_result_nxt;
      r_valid  <= w_valid_nxt;
      r_ovr    <= w_ovr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  assign bus.sample = r_sample;
  assign bus.dac    = r_dac;
  assign bus.result = r_result;
  assign bus.valid  = r_valid;
  assign bus.ovr    = r_ovr;
  assign bus.busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Bench for sar_seq_ctrl: timeline model of a conversion checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sar_seq_ctrl;
  localparam int NB = 8;
  localparam int SC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vin   = 0;

  int n_total = 0;
  int n_bad   = 0;

  // Model: position in the conversion timeline (0 idle, 1..SC sampling,
  // SC+1..SC+NB bit trials, SC+NB+1 done), plus result status.
  int m_pos    = 0;
  int m_result = 0;
  int m_valid  = 0;
  int m_ovr    = 0;

  sar_seq_ctrl_if #(.NBITS(NB)) bus();

  sar_seq_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.cmp = (vin >= int'(bus.dac));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Trial k keeps the top k bits of the input and raises the next one.
  function automatic int exp_dac(input int pos, input int v);
    int k;
    int keep;
    k    = pos - SC - 1;
    keep = v & ~((1 << (NB - k)) - 1) & ((1 << NB) - 1);
    return keep | (1 << (NB - 1 - k));
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pos = 0; m_valid = 0; m_ovr = 0; m_result = 0;
    end else begin
      int done_e;
      int a;
      a      = int'(bus.ack);
      done_e = (m_pos == SC + NB) ? 1 : 0;
      if (!bus.ena) begin
        m_pos = 0;
        m_ovr = 0;
        if (a != 0) m_valid = 0;
      end else begin
        if (m_pos == 0 || m_pos == SC + NB + 1) m_pos = bus.start ? 1 : 0;
        else m_pos++;
        if (done_e != 0) begin
          if (m_valid != 0 && a == 0) m_ovr = 1;
          m_valid  = 1;
          m_result = vin;
        end else if (a != 0) begin
          m_valid = 0;
        end
      end
      #1;
      if (rst_n) begin
        chk("m_sample", int'(bus.sample), (m_pos >= 1 && m_pos <= SC) ? 1 : 0);
        chk("m_dac", int'(bus.dac),
            (m_pos > SC && m_pos <= SC + NB) ? exp_dac(m_pos, vin) : 0);
        chk("m_busy", int'(bus.busy), (m_pos != 0) ? 1 : 0);
        chk("m_valid", int'(bus.valid), m_valid);
        chk("m_result", int'(bus.result), m_result);
        chk("m_ovr", int'(bus.ovr), m_ovr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic conv(input int v, input bit ack_at_done);
    vin       = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    if (ack_at_done) bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    step();
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while (bus.busy && k < max_cycles) begin
      step();
      k++;
    end
    chk("idle_timeout", int'(bus.busy), 0);
  endtask

  initial begin
    int seq [8];
    seq = '{'h80, 'hC0, 'hA0, 'hB0, 'hA8, 'hA4, 'hA6, 'hA5};
    bus.ena = 1'b0; bus.start = 1'b0; bus.ack = 1'b0;

    #1;
    chk("rst_sample", int'(bus.sample), 0);
    chk("rst_dac", int'(bus.dac), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_ovr", int'(bus.ovr), 0);
    chk("rst_busy", int'(bus.busy), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single conversion of 0xA5 with the exact trial sequence
    bus.ena = 1'b1; vin = 'hA5; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i >= 2 && i <= 9) begin
        chk("t031_dac", int'(bus.dac), seq[i-2]);
        chk("t031_model_dac", exp_dac(m_pos, vin), seq[i-2]);
      end
      if (i == 9) chk("t031_valid_early", int'(bus.valid), 0);
    end
    chk("t031_valid", int'(bus.valid), 1);
    chk("t031_result", int'(bus.result), 'hA5);
    chk("t031_dac_done", int'(bus.dac), 0);
    ack_pulse();
    chk("t031_ack_valid", int'(bus.valid), 0);
    chk("t031_idle", int'(bus.busy), 0);

    // Full-scale and zero inputs
    conv('hFF, 1'b0);
    chk("t032_ff", int'(bus.result), 'hFF);
    chk("t032_ovr_a", int'(bus.ovr), 0);
    ack_pulse();
    conv('h00, 1'b0);
    chk("t032_00", int'(bus.result), 'h00);
    chk("t032_ovr_b", int'(bus.ovr), 0);

    // Ack coincident with completion while previous result unread
    conv('h5A, 1'b1);
    chk("t036_valid", int'(bus.valid), 1);
    chk("t036_result", int'(bus.result), 'h5A);
    chk("t036_ovr", int'(bus.ovr), 0);
    ack_pulse();
    chk("t036_ack", int'(bus.valid), 0);

    // Continuous conversions, no ack
    vin = 'h3C; bus.start = 1'b1;
    step();
    for (int i = 1; i <= 22; i++) begin
      step();
      if (i == 10) begin
        chk("t033_valid1", int'(bus.valid), 1);
        chk("t033_ovr1", int'(bus.ovr), 0);
      end
      if (i == 11) chk("t033_resample", int'(bus.sample), 1);
      if (i == 20) chk("t033_ovr_pre", int'(bus.ovr), 0);
      if (i == 21) begin
        chk("t033_ovr2", int'(bus.ovr), 1);
        chk("t033_valid2", int'(bus.valid), 1);
      end
    end
    ack_pulse();
    chk("t033_ack_valid", int'(bus.valid), 0);
    chk("t033_ack_ovr", int'(bus.ovr), 1);
    bus.start = 1'b0;
    wait_idle(40);
    chk("t033_ovr_sticky", int'(bus.ovr), 1);
    bus.ena = 1'b0;
    step();
    chk("t033_ovr_clr", int'(bus.ovr), 0);
    bus.ena = 1'b1;

    // Abort during the bit-4 trial
    vin = 'hA5; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    chk("t034_dac_idx4", int'(bus.dac), 'hB0);
    bus.ena = 1'b0;
    step();
    chk("t034_busy", int'(bus.busy), 0);
    chk("t034_dac", int'(bus.dac), 0);
    chk("t034_sample", int'(bus.sample), 0);
    chk("t034_valid", int'(bus.valid), 1);
    chk("t034_result", int'(bus.result), 'h3C);
    bus.ena = 1'b1;
    conv('h6B, 1'b0);
    chk("t034_fresh", int'(bus.result), 'h6B);
    chk("t034_ovr", int'(bus.ovr), 1);
    ack_pulse();

    // Asynchronous reset in the middle of sampling
    vin = 'hC3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("t035_sampling", int'(bus.sample), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t035_sample", int'(bus.sample), 0);
    chk("t035_dac", int'(bus.dac), 0);
    chk("t035_result", int'(bus.result), 0);
    chk("t035_valid", int'(bus.valid), 0);
    chk("t035_ovr", int'(bus.ovr), 0);
    chk("t035_busy", int'(bus.busy), 0);
    #1;
    rst_n = 1'b1;
    step();
    conv('hC3, 1'b0);
    chk("t035_result_after", int'(bus.result), 'hC3);
    chk("t035_valid_after", int'(bus.valid), 1);

    // Randomized traffic against the timeline model
    for (int c = 0; c < 3000; c++) begin
      step();
      bus.ena   = ($urandom_range(0, 29) != 0);
      bus.start = ($urandom_range(0, 3) != 0);
      bus.ack   = bus.ena && ($urandom_range(0, 5) == 0);
      if (m_pos <= SC || m_pos == SC + NB + 1) begin
        if ($urandom_range(0, 2) == 0) vin = int'($urandom_range(0, 255));
      end
    end
    step();
    bus.ena = 1'b1; bus.start = 1'b0; bus.ack = 1'b0;
    wait_idle(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
